// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Build option ALU_ARB_RR_EN: round-robin ties; else fixed priority + starve guard.
module alu_arbiter #(
    parameter int CPU_WIDTH    = 32,
    parameter int ALU_OP_WIDTH = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [ALU_OP_WIDTH-1:0] req0_op,
    input  logic [CPU_WIDTH-1:0]    req0_src1,
    input  logic [CPU_WIDTH-1:0]    req0_src2,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [ALU_OP_WIDTH-1:0] req1_op,
    input  logic [CPU_WIDTH-1:0]    req1_src1,
    input  logic [CPU_WIDTH-1:0]    req1_src2,
    output logic                    rsp0_valid,
    input  logic                    rsp0_ready,
    output logic [CPU_WIDTH-1:0]    rsp0_res,
    output logic                    rsp1_valid,
    input  logic                    rsp1_ready,
    output logic [CPU_WIDTH-1:0]    rsp1_res,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic [CPU_WIDTH-1:0]    alu_src1,
    output logic [CPU_WIDTH-1:0]    alu_src2,
    input  logic [CPU_WIDTH-1:0]    alu_res
);

    logic                 elig0, elig1;
    logic                 grant0, grant1;
    logic                 rsp0_valid_q, rsp0_valid_d;
    logic                 rsp1_valid_q, rsp1_valid_d;
    logic [CPU_WIDTH-1:0] rsp0_res_q, rsp0_res_d;
    logic [CPU_WIDTH-1:0] rsp1_res_q, rsp1_res_d;

    // A port may issue when its slot is empty or draining this cycle
    always_comb begin
        elig0 = req0_valid && (!rsp0_valid_q || rsp0_ready);
        elig1 = req1_valid && (!rsp1_valid_q || rsp1_ready);
    end

`ifdef ALU_ARB_RR_EN
    logic last_gnt_q, last_gnt_d;

    // Tie goes to the port that did not win last; nothing granted in reset
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (elig0 && elig1) begin
                if (last_gnt_q) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    // Remember the most recent winner
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (grant0) begin
            last_gnt_d = 1'b0;
        end else if (grant1) begin
            last_gnt_d = 1'b1;
        end
    end

    // Reset to 1 so port 0 takes the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`else
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

    logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;
    logic            starve_hit;

    // Port 0 wins ties unless port 1 has lost STARVE_LIMIT times in a row
    always_comb begin
        starve_hit = (starve_cnt_q == SC_MAX);
        grant0     = 1'b0;
        grant1     = 1'b0;
        if (!rst) begin
            if (elig0 && elig1) begin
                if (starve_hit) begin
                    grant1 = 1'b1;
                end else begin
                    grant0 = 1'b1;
                end
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    // Count consecutive losses of an eligible port 1, saturating
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant1 || !elig1) begin
            starve_cnt_d = '0;
        end else if (grant0 && !starve_hit) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    // Steer the winner onto the ALU; idle inputs are forced to zero
    always_comb begin
        alu_op   = '0;
        alu_src1 = '0;
        alu_src2 = '0;
        if (grant0) begin
            alu_op   = req0_op;
            alu_src1 = req0_src1;
            alu_src2 = req0_src2;
        end else if (grant1) begin
            alu_op   = req1_op;
            alu_src1 = req1_src1;
            alu_src2 = req1_src2;
        end
    end

    // Slot update: refill on grant wins over drain
    always_comb begin
        rsp0_valid_d = rsp0_valid_q;
        rsp0_res_d   = rsp0_res_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp1_res_d   = rsp1_res_q;
        if (grant0) begin
            rsp0_valid_d = 1'b1;
            rsp0_res_d   = alu_res;
        end else if (rsp0_valid_q && rsp0_ready) begin
            rsp0_valid_d = 1'b0;
        end
        if (grant1) begin
            rsp1_valid_d = 1'b1;
            rsp1_res_d   = alu_res;
        end else if (rsp1_valid_q && rsp1_ready) begin
            rsp1_valid_d = 1'b0;
        end
    end

    // Response slot registers; reset discards pending results
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid_q <= 1'b0;
            rsp0_res_q   <= '0;
            rsp1_valid_q <= 1'b0;
            rsp1_res_q   <= '0;
        end else begin
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_res_q   <= rsp0_res_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_res_q   <= rsp1_res_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_res   = rsp0_res_q;
    assign rsp1_res   = rsp1_res_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed stimulus for alu_arbiter with a cycle model.
// Build option ALU_ARB_RR_EN selects round-robin expectations.
module tb_alu_arbiter;

    localparam int W  = 32;
    localparam int OW = 4;
    localparam int SL = 4;

    localparam logic [OW-1:0] OP_ADD = 4'd0;
    localparam logic [OW-1:0] OP_SUB = 4'd1;
    localparam logic [OW-1:0] OP_XOR = 4'd2;

    logic          clk;
    logic          rst;
    logic          req0_valid, req0_ready;
    logic [OW-1:0] req0_op;
    logic [W-1:0]  req0_src1, req0_src2;
    logic          req1_valid, req1_ready;
    logic [OW-1:0] req1_op;
    logic [W-1:0]  req1_src1, req1_src2;
    logic          rsp0_valid, rsp0_ready;
    logic [W-1:0]  rsp0_res;
    logic          rsp1_valid, rsp1_ready;
    logic [W-1:0]  rsp1_res;
    logic [OW-1:0] alu_op;
    logic [W-1:0]  alu_src1, alu_src2, alu_res;

    int n_tests = 0;
    int n_fail  = 0;

    alu_arbiter #(
        .CPU_WIDTH(W), .ALU_OP_WIDTH(OW), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_src1(req0_src1), .req0_src2(req0_src2),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_src1(req1_src1), .req1_src2(req1_src2),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res(rsp0_res),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res(rsp1_res),
        .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_res(alu_res)
    );

    function automatic logic [W-1:0] ref_alu(
        input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b
    );
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_res = ref_alu(alu_op, alu_src1, alu_src2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected winner (1 = port 1) of the k-th cycle of continuous contention
    function automatic logic exp_grant(input int k);
`ifdef ALU_ARB_RR_EN
        return (k % 2) == 1;
`else
        return (k % (SL + 1)) == SL;
`endif
    endfunction

    // Model state
    logic         m_v0 = 1'b0, m_v1 = 1'b0;
    logic [W-1:0] m_r0 = '0, m_r1 = '0;
    logic         m_last = 1'b1;
    int           m_starve = 0;

    // Per-cycle compare against the model, then advance the model
    always @(negedge clk) begin : model
        logic e0, e1, g0, g1;
        logic [OW-1:0] xop;
        logic [W-1:0]  xa, xb;
        e0 = req0_valid && (!m_v0 || rsp0_ready);
        e1 = req1_valid && (!m_v1 || rsp1_ready);
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst) begin
            if (e0 && e1) begin
`ifdef ALU_ARB_RR_EN
                g1 = !m_last;
`else
                g1 = (m_starve >= SL);
`endif
                g0 = !g1;
            end else begin
                g0 = e0;
                g1 = e1;
            end
        end
        xop = '0;
        xa  = '0;
        xb  = '0;
        if (g0) begin
            xop = req0_op; xa = req0_src1; xb = req0_src2;
        end
        if (g1) begin
            xop = req1_op; xa = req1_src1; xb = req1_src2;
        end
        chk("m_req0_ready", req0_ready, g0);
        chk("m_req1_ready", req1_ready, g1);
        chk("m_alu_op", alu_op, xop);
        chk("m_alu_src1", alu_src1, xa);
        chk("m_alu_src2", alu_src2, xb);
        chk("m_rsp0_valid", rsp0_valid, m_v0);
        chk("m_rsp1_valid", rsp1_valid, m_v1);
        chk("m_rsp0_res", rsp0_res, m_r0);
        chk("m_rsp1_res", rsp1_res, m_r1);
        if (rst) begin
            m_v0 = 0; m_v1 = 0; m_r0 = '0; m_r1 = '0;
            m_last = 1'b1; m_starve = 0;
        end else begin
            if (g0) begin
                m_v0 = 1'b1; m_r0 = ref_alu(xop, xa, xb);
            end else if (m_v0 && rsp0_ready) begin
                m_v0 = 1'b0;
            end
            if (g1) begin
                m_v1 = 1'b1; m_r1 = ref_alu(xop, xa, xb);
            end else if (m_v1 && rsp1_ready) begin
                m_v1 = 1'b0;
            end
            if (g0) m_last = 1'b0;
            if (g1) m_last = 1'b1;
            if (g1 || !e1) m_starve = 0;
            else if (g0 && m_starve < SL) m_starve = m_starve + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_op = OP_ADD; req0_src1 = 1; req0_src2 = 2;
        req1_valid = 1'b1; req1_op = OP_SUB; req1_src1 = 9; req1_src2 = 4;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // Reset with both requests pending
        repeat (3) begin
            @(negedge clk);
            chk("rst_req0_ready", req0_ready, 0);
            chk("rst_req1_ready", req1_ready, 0);
            chk("rst_rsp0_valid", rsp0_valid, 0);
            chk("rst_rsp1_valid", rsp1_valid, 0);
            chk("rst_alu_src1", alu_src1, 0);
            chk("rst_rsp0_res", rsp0_res, 0);
        end

        // Single port ADD 5+7
        step();
        rst = 1'b0;
        req1_valid = 1'b0;
        req0_op = OP_ADD; req0_src1 = 5; req0_src2 = 7;
        @(negedge clk);
        chk("single_req0_ready", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("single_rsp0_valid", rsp0_valid, 1);
        chk("single_rsp0_res", rsp0_res, 12);

        // Backpressure on port 1
        step();
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_op = OP_SUB; req1_src1 = 'h10; req1_src2 = 'h3;
        @(negedge clk);
        chk("bp_first_accept", req1_ready, 1);
        step();
        req1_op = OP_ADD; req1_src1 = 'h20; req1_src2 = 'h1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_rsp1_valid", rsp1_valid, 1);
            chk("bp_rsp1_res", rsp1_res, 'hD);
            chk("bp_req1_stall", req1_ready, 0);
            step();
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        chk("bp_refill_ready", req1_ready, 1);
        step();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("bp_refill_valid", rsp1_valid, 1);
        chk("bp_refill_res", rsp1_res, 'h21);
        step();
        @(negedge clk);
        chk("bp_drained", rsp1_valid, 0);

        // Continuous contention from reset
        step();
        rst = 1'b1;
        req0_valid = 1'b1; req0_op = OP_XOR; req0_src1 = 'hF0; req0_src2 = 'h0F;
        req1_valid = 1'b1; req1_op = OP_SUB; req1_src1 = 100; req1_src2 = 1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("cont_one_grant", req0_ready ^ req1_ready, 1);
            chk($sformatf("cont_grant_%0d", k), req1_ready, exp_grant(k));
            step();
        end
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("restart_grant_%0d", k), req1_ready, exp_grant(k));
            step();
        end

        // Fill both slots, then reset mid-operation
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        step();
        step();
        step();
        @(negedge clk);
        chk("full_rsp0_valid", rsp0_valid, 1);
        chk("full_rsp1_valid", rsp1_valid, 1);
        chk("full_rsp0_res", rsp0_res, 'hFF);
        chk("full_rsp1_res", rsp1_res, 99);
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_rsp0_valid", rsp0_valid, 0);
        chk("midrst_rsp1_valid", rsp1_valid, 0);
        chk("midrst_rsp0_res", rsp0_res, 0);
        chk("midrst_rsp1_res", rsp1_res, 0);
        chk("midrst_req0_ready", req0_ready, 0);
        step();
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
